vend_credit_ctrl: RTL and testbench
===================================

// Module: vend_credit_ctrl
// PURPOSE
//  Credit and dispense controller for the digital vending machine; successor to the single-gate test blocks.
//  - Accepts coins, accumulates credit and checks a product selection against a per-item price.
//  - Issues a one-cycle dispense strobe, then returns change one coin per cycle.
//  - Sits between the coin-acceptor front end and the dispenser/coin-return actuators.
// PARAMETERS
//  NUM_ITEMS   4    number of selectable products (>=2)
//  CREDIT_W    8    width of credit/price arithmetic
//  MAX_CREDIT  200  credit ceiling in cents (< 2**CREDIT_W)
//  PRICE_BASE  65   price of item 0 in cents (multiple of 5)
//  PRICE_STEP  10   price(i) = PRICE_BASE + i*PRICE_STEP
// PORTS
//  clk            in   1              system clock, rising edge
//  rst            in   1              synchronous, active-high reset
//  coin_valid     in   1              coin present this cycle
//  coin_type      in   2              00=5c 01=10c 10=25c 11=invalid
//  sel_valid      in   1              product selection strobe
//  sel_id         in   $clog2(NUM_ITEMS)  selected product index
//  cancel         in   1              refund request (VEND_CANCEL_EN only)
//  credit         out  CREDIT_W       current credit in cents
//  coin_reject    out  1              1-cycle pulse: coin not accepted
//  sel_denied     out  1              1-cycle pulse: selection refused
//  dispense_valid out  1              1-cycle pulse: release product
//  dispense_id    out  $clog2(NUM_ITEMS)  product index, valid with dispense_valid
//  change_valid   out  1              1-cycle pulse per change coin
//  change_coin    out  2              coin code of returned coin (same encoding)
//  busy           out  1              high in VEND and CHANGE
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; credit 0. Reset mid-vend or mid-change aborts with no further pulses.
//  - States:
//    - IDLE: credit==0.
//    - CREDIT: credit>0.
//    - VEND: 1 cycle; dispense_valid=1.
//    - CHANGE: returns remainder, then IDLE.
//  - Coin (IDLE/CREDIT): accept if credit+value <= MAX_CREDIT; credit updates next cycle; IDLE->CREDIT.
//  - Coin rejection: coin_type 11, overflow, or arrival in VEND/CHANGE -> coin_reject next cycle, credit unchanged.
//  - Selection (CREDIT only): granted if sel_id<NUM_ITEMS and credit>=price(sel_id).
//    - Grant at cycle N: credit<=credit-price, VEND at N+1 with dispense_id latched.
//    - At N+2: CHANGE if remainder>0, else IDLE.
//    - Refusal: sel_denied at N+1, state/credit unchanged. sel_valid in IDLE or busy -> sel_denied.
//  - Simultaneous coin and selection: selection wins and is judged on pre-coin credit; the coin is rejected.
//  - CHANGE: greedy, largest first (25,10,5).
//    - One coin per cycle: change_valid=1, change_coin=code, credit decremented the same edge.
//    - Leave to IDLE on the cycle credit reaches 0.
//  - Arithmetic: unsigned CREDIT_W; no wrap possible (ceiling enforced). Remainder always a multiple of 5.
//  - credit is registered; all pulses are registered outputs.
// CONFIGURATION
//  - VEND_CANCEL_EN defined:
//    - cancel in CREDIT enters CHANGE next cycle, returning all credit.
//    - cancel with sel_valid: selection wins.
//    - cancel ignored in IDLE/VEND/CHANGE.
//  - VEND_CANCEL_EN undefined: cancel port still present but ignored; credit is held until a vend.
// STRUCTURE
//  - Package vend_pkg:
//    - coin code localparams COIN_5/COIN_10/COIN_25/COIN_BAD.
//    - coin_value function.
//    - state enum {IDLE,CREDIT,VEND,CHANGE}.
//  - Sub-module vend_change_gen: combinational greedy coin picker (remainder -> coin code, value); instantiated once.
//  - Top: FSM, credit register, price compute.
// TESTING
//  - Reset: assert rst 2 cycles mid-CHANGE -> credit=0, busy=0, no change_valid afterwards.
//  - Exact price: coins 25,25,10,5 (credit=65), sel_id=0 -> dispense_valid 1 cycle, dispense_id=0, no change, IDLE.
//  - Change: 3x25 (75), sel_id=0 -> dispense, then change_valid once with COIN_10; credit ends 0.
//  - Denial: credit 50, sel_id=3 (price 95) -> sel_denied, credit stays 50. sel_id=1 at 0 credit -> sel_denied.
//  - Overflow: credit 190, coin 25 -> coin_reject, credit 190. coin_type 11 -> coin_reject.
//  - Collision: credit 75, sel_id=1 and coin 25 same cycle -> dispense id 1, coin_reject, change 0.
//    With VEND_CANCEL_EN: credit 40, cancel -> change 25,10,5 on 3 consecutive cycles.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vending credit controller: coin codes,
// coin values and the controller state encoding.
package vend_pkg;

  // Coin codes shared by the coin acceptor input and the change output.
  localparam logic [1:0] COIN_5   = 2'b00;
  localparam logic [1:0] COIN_10  = 2'b01;
  localparam logic [1:0] COIN_25  = 2'b10;
  localparam logic [1:0] COIN_BAD = 2'b11;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CREDIT = 2'b01,
    VEND   = 2'b10,
    CHANGE = 2'b11
  } state_t;

  // Face value in cents of a coin code. An invalid code is worth nothing.
  function automatic logic [4:0] coin_value(input logic [1:0] code);
    logic [4:0] val;
    case (code)
      COIN_5:  val = 5'd5;
      COIN_10: val = 5'd10;
      COIN_25: val = 5'd25;
      default: val = 5'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/vend_change_gen.sv
// Greedy change picker: given the outstanding remainder, selects the
// largest coin (25, 10, 5) that does not exceed it. Purely combinational.
module vend_change_gen
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] remainder,
  output logic [1:0]          coin_code,
  output logic [CREDIT_W-1:0] coin_val
);

  // Largest coin that fits; a remainder below 5 yields no coin.
  always_comb begin
    coin_code = COIN_BAD;
    coin_val  = '0;
    if (remainder >= CREDIT_W'(25)) begin
      coin_code = COIN_25;
      coin_val  = CREDIT_W'(25);
    end else if (remainder >= CREDIT_W'(10)) begin
      coin_code = COIN_10;
      coin_val  = CREDIT_W'(10);
    end else if (remainder >= CREDIT_W'(5)) begin
      coin_code = COIN_5;
      coin_val  = CREDIT_W'(5);
    end
  end

endmodule

// File: rtl/vend_credit_ctrl.sv
// Credit and dispense controller: accumulates coin credit, judges product
// selections against per-item prices, pulses dispense, then pays change
// one coin per cycle. Optional build macro VEND_CANCEL_EN enables the
// cancel/refund input; without it the cancel port is ignored.
module vend_credit_ctrl
  import vend_pkg::*;
#(
  parameter  int NUM_ITEMS  = 4,
  parameter  int CREDIT_W   = 8,
  parameter  int MAX_CREDIT = 200,
  parameter  int PRICE_BASE = 65,
  parameter  int PRICE_STEP = 10,
  localparam int SEL_W      = $clog2(NUM_ITEMS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel_id,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                sel_denied,
  output logic                dispense_valid,
  output logic [SEL_W-1:0]    dispense_id,
  output logic                change_valid,
  output logic [1:0]          change_coin,
  output logic                busy
);

  state_t              state, state_n;
  logic [CREDIT_W-1:0] credit_n;
  logic                coin_reject_n, sel_denied_n;
  logic                dispense_valid_n, change_valid_n;
  logic [SEL_W-1:0]    dispense_id_n;
  logic [1:0]          change_coin_n;

  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_ok;
  logic [CREDIT_W-1:0] price;
  logic                sel_ok;
  logic                cancel_hit;
  logic [1:0]          chg_code;
  logic [CREDIT_W-1:0] chg_val;

  // Coin acceptance: valid code and the new total stays within the ceiling.
  // The sum is one bit wider so the ceiling check itself cannot wrap.
  assign coin_val = CREDIT_W'(coin_value(coin_type));
  assign coin_sum = {1'b0, credit} + {1'b0, coin_val};
  assign coin_ok  = (coin_type != COIN_BAD) &&
                    (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));

  // Price of the selected item and whether the current credit covers it.
  assign price  = CREDIT_W'(PRICE_BASE + int'(sel_id) * PRICE_STEP);
  assign sel_ok = (int'(sel_id) < NUM_ITEMS) && (credit >= price);

`ifdef VEND_CANCEL_EN
  // Refund request only matters while holding credit.
  assign cancel_hit = cancel && (state == CREDIT);
`else
  // Cancel is not honoured in this build; credit waits for a vend.
  logic unused_cancel;
  assign unused_cancel = cancel;
  assign cancel_hit    = 1'b0;
`endif

  vend_change_gen #(
    .CREDIT_W (CREDIT_W)
  ) u_change_gen (
    .remainder (credit),
    .coin_code (chg_code),
    .coin_val  (chg_val)
  );

  assign busy = (state == VEND) || (state == CHANGE);

  // Next-state, next-credit and next-pulse decisions.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can
    // leave one unassigned, which would otherwise infer a latch.
    state_n          = state;
    credit_n         = credit;
    coin_reject_n    = 1'b0;
    sel_denied_n     = 1'b0;
    dispense_valid_n = 1'b0;
    dispense_id_n    = dispense_id;
    change_valid_n   = 1'b0;
    change_coin_n    = '0;

    case (state)
      IDLE, CREDIT: begin
        if (sel_valid) begin
          // Selection wins over a same-cycle coin and is judged on the
          // pre-coin credit; the coin goes back.
          coin_reject_n = coin_valid;
          if ((state == CREDIT) && sel_ok) begin
            credit_n         = credit - price;
            dispense_valid_n = 1'b1;
            dispense_id_n    = sel_id;
            state_n          = VEND;
          end else begin
            sel_denied_n = 1'b1;
          end
        end else if (cancel_hit) begin
          coin_reject_n = coin_valid;
          state_n       = CHANGE;
        end else if (coin_valid) begin
          if (coin_ok) begin
            credit_n = coin_sum[CREDIT_W-1:0];
            state_n  = CREDIT;
          end else begin
            coin_reject_n = 1'b1;
          end
        end
      end

      VEND: begin
        coin_reject_n = coin_valid;
        sel_denied_n  = sel_valid;
        state_n       = (credit != '0) ? CHANGE : IDLE;
      end

      CHANGE: begin
        coin_reject_n  = coin_valid;
        sel_denied_n   = sel_valid;
        change_valid_n = 1'b1;
        change_coin_n  = chg_code;
        credit_n       = credit - chg_val;
        if (credit_n == '0) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  // State, credit and output pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state          <= IDLE;
      credit         <= '0;
      coin_reject    <= 1'b0;
      sel_denied     <= 1'b0;
      dispense_valid <= 1'b0;
      dispense_id    <= '0;
      change_valid   <= 1'b0;
      change_coin    <= '0;
    end else begin
      state          <= state_n;
      credit         <= credit_n;
      coin_reject    <= coin_reject_n;
      sel_denied     <= sel_denied_n;
      dispense_valid <= dispense_valid_n;
      dispense_id    <= dispense_id_n;
      change_valid   <= change_valid_n;
      change_coin    <= change_coin_n;
    end
  end

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Directed testbench for vend_credit_ctrl. Inputs change 1 ns after the
// rising edge, outputs are read at the same point (after settling).
module tb_vend_credit_ctrl;

  localparam logic [1:0] C5   = 2'b00;
  localparam logic [1:0] C10  = 2'b01;
  localparam logic [1:0] C25  = 2'b10;
  localparam logic [1:0] CBAD = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       sel_valid;
  logic [1:0] sel_id;
  logic       cancel;
  logic [7:0] credit;
  logic       coin_reject, sel_denied, dispense_valid, change_valid, busy;
  logic [1:0] dispense_id, change_coin;

  int total = 0;
  int bad   = 0;

  vend_credit_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .coin_valid     (coin_valid),
    .coin_type      (coin_type),
    .sel_valid      (sel_valid),
    .sel_id         (sel_id),
    .cancel         (cancel),
    .credit         (credit),
    .coin_reject    (coin_reject),
    .sel_denied     (sel_denied),
    .dispense_valid (dispense_valid),
    .dispense_id    (dispense_id),
    .change_valid   (change_valid),
    .change_coin    (change_coin),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; coin_valid = 1'b0; coin_type = C5;
    sel_valid = 1'b0; sel_id = 2'd0; cancel = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic coin(input logic [1:0] t);
    coin_valid = 1'b1; coin_type = t;
    step();
    coin_valid = 1'b0;
  endtask

  task automatic select(input logic [1:0] id);
    sel_valid = 1'b1; sel_id = id;
    step();
    sel_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({credit, busy, coin_reject, sel_denied, dispense_valid, change_valid} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs credit=%0d busy=%b pulses=%b%b%b%b want all 0",
               credit, busy, coin_reject, sel_denied, dispense_valid, change_valid);
    end
    // 190 credit, buy item 0 -> 125 remainder (five 25c coins).
    for (int i = 0; i < 7; i++) coin(C25);
    coin(C10); coin(C5);
    select(2'd0);                // VEND
    step();                      // CHANGE
    step();                      // first coin out
    total++;
    if (change_valid !== 1'b1 || credit !== 8'd100) begin
      bad++;
      $display("FAIL reset_pre_change change_valid=%b credit=%0d want 1/100", change_valid, credit);
    end
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    total++;
    if (credit !== 8'd0 || busy !== 1'b0 || change_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_change credit=%0d busy=%b change_valid=%b want 0/0/0",
               credit, busy, change_valid);
    end
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        step();
        if (change_valid === 1'b1 || busy === 1'b1) seen++;
      end
      total++;
      if (seen !== 0) begin
        bad++;
        $display("FAIL reset_no_more_change pulses_after_reset=%0d want 0", seen);
      end
    end
  endtask

  task automatic test_exact_price();
    do_reset();
    coin(C25); coin(C25); coin(C10); coin(C5);
    total++;
    if (credit !== 8'd65) begin
      bad++;
      $display("FAIL exact_credit credit=%0d want 65", credit);
    end
    select(2'd0);
    total++;
    if (dispense_valid !== 1'b1 || dispense_id !== 2'd0 || credit !== 8'd0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL exact_vend dv=%b id=%0d credit=%0d busy=%b want 1/0/0/1",
               dispense_valid, dispense_id, credit, busy);
    end
    step();
    total++;
    if (dispense_valid !== 1'b0 || busy !== 1'b0 || change_valid !== 1'b0) begin
      bad++;
      $display("FAIL exact_idle dv=%b busy=%b cv=%b want 0/0/0", dispense_valid, busy, change_valid);
    end
    step();
    total++;
    if (change_valid !== 1'b0 || credit !== 8'd0) begin
      bad++;
      $display("FAIL exact_no_change cv=%b credit=%0d want 0/0", change_valid, credit);
    end
  endtask

  task automatic test_change();
    do_reset();
    coin(C25); coin(C25); coin(C25);
    select(2'd0);
    total++;
    if (dispense_valid !== 1'b1 || credit !== 8'd10) begin
      bad++;
      $display("FAIL change_vend dv=%b credit=%0d want 1/10", dispense_valid, credit);
    end
    coin(C5);                    // arrives in VEND -> rejected
    total++;
    if (coin_reject !== 1'b1 || credit !== 8'd10 || busy !== 1'b1 || change_valid !== 1'b0) begin
      bad++;
      $display("FAIL change_busy_coin rej=%b credit=%0d busy=%b cv=%b want 1/10/1/0",
               coin_reject, credit, busy, change_valid);
    end
    step();
    total++;
    if (change_valid !== 1'b1 || change_coin !== C10 || credit !== 8'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL change_coin cv=%b coin=%b credit=%0d busy=%b want 1/01/0/0",
               change_valid, change_coin, credit, busy);
    end
    step();
    total++;
    if (change_valid !== 1'b0) begin
      bad++;
      $display("FAIL change_single cv=%b want 0", change_valid);
    end
  endtask

  task automatic test_change_multi();
    do_reset();
    coin(C25); coin(C25); coin(C25); coin(C5);   // 80
    select(2'd0);                                // remainder 15
    step();                                      // CHANGE
    step();
    total++;
    if (change_valid !== 1'b1 || change_coin !== C10 || credit !== 8'd5) begin
      bad++;
      $display("FAIL multi_first cv=%b coin=%b credit=%0d want 1/01/5", change_valid, change_coin, credit);
    end
    step();
    total++;
    if (change_valid !== 1'b1 || change_coin !== C5 || credit !== 8'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL multi_second cv=%b coin=%b credit=%0d busy=%b want 1/00/0/0",
               change_valid, change_coin, credit, busy);
    end
  endtask

  task automatic test_denial();
    do_reset();
    coin(C25); coin(C25);
    select(2'd3);
    total++;
    if (sel_denied !== 1'b1 || credit !== 8'd50 || dispense_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL deny_price den=%b credit=%0d dv=%b busy=%b want 1/50/0/0",
               sel_denied, credit, dispense_valid, busy);
    end
    step();
    total++;
    if (sel_denied !== 1'b0 || credit !== 8'd50) begin
      bad++;
      $display("FAIL deny_pulse den=%b credit=%0d want 0/50", sel_denied, credit);
    end
    do_reset();
    select(2'd1);
    total++;
    if (sel_denied !== 1'b1 || dispense_valid !== 1'b0) begin
      bad++;
      $display("FAIL deny_idle den=%b dv=%b want 1/0", sel_denied, dispense_valid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 7; i++) coin(C25);
    coin(C10); coin(C5);
    total++;
    if (credit !== 8'd190) begin
      bad++;
      $display("FAIL ovf_build credit=%0d want 190", credit);
    end
    coin(C25);
    total++;
    if (coin_reject !== 1'b1 || credit !== 8'd190) begin
      bad++;
      $display("FAIL ovf_reject rej=%b credit=%0d want 1/190", coin_reject, credit);
    end
    coin(CBAD);
    total++;
    if (coin_reject !== 1'b1 || credit !== 8'd190) begin
      bad++;
      $display("FAIL bad_coin rej=%b credit=%0d want 1/190", coin_reject, credit);
    end
    coin(C10);                   // exactly at the 200 ceiling
    total++;
    if (coin_reject !== 1'b0 || credit !== 8'd200) begin
      bad++;
      $display("FAIL ceiling_accept rej=%b credit=%0d want 0/200", coin_reject, credit);
    end
    coin(C5);
    total++;
    if (coin_reject !== 1'b1 || credit !== 8'd200) begin
      bad++;
      $display("FAIL ceiling_reject rej=%b credit=%0d want 1/200", coin_reject, credit);
    end
  endtask

  task automatic test_collision();
    do_reset();
    coin(C25); coin(C25); coin(C25);
    coin_valid = 1'b1; coin_type = C25;
    select(2'd1);
    coin_valid = 1'b0;
    total++;
    if (dispense_valid !== 1'b1 || dispense_id !== 2'd1 || coin_reject !== 1'b1 || credit !== 8'd0) begin
      bad++;
      $display("FAIL collide_vend dv=%b id=%0d rej=%b credit=%0d want 1/1/1/0",
               dispense_valid, dispense_id, coin_reject, credit);
    end
    step(); step();
    total++;
    if (change_valid !== 1'b0 || busy !== 1'b0 || credit !== 8'd0) begin
      bad++;
      $display("FAIL collide_after cv=%b busy=%b credit=%0d want 0/0/0", change_valid, busy, credit);
    end
  endtask

  task automatic test_cancel();
    do_reset();
    coin(C25); coin(C10); coin(C5);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
`ifdef VEND_CANCEL_EN
    total++;
    if (busy !== 1'b1 || credit !== 8'd40) begin
      bad++;
      $display("FAIL cancel_enter busy=%b credit=%0d want 1/40", busy, credit);
    end
    begin
      logic [1:0] exp_coin [3];
      logic [7:0] exp_cred [3];
      exp_coin[0] = C25; exp_coin[1] = C10; exp_coin[2] = C5;
      exp_cred[0] = 8'd15; exp_cred[1] = 8'd5; exp_cred[2] = 8'd0;
      for (int i = 0; i < 3; i++) begin
        step();
        total++;
        if (change_valid !== 1'b1 || change_coin !== exp_coin[i] || credit !== exp_cred[i]) begin
          bad++;
          $display("FAIL cancel_coin%0d cv=%b coin=%b credit=%0d want 1/%b/%0d",
                   i, change_valid, change_coin, credit, exp_coin[i], exp_cred[i]);
        end
      end
    end
`else
    total++;
    if (busy !== 1'b0 || credit !== 8'd40 || change_valid !== 1'b0) begin
      bad++;
      $display("FAIL cancel_ignored busy=%b credit=%0d cv=%b want 0/40/0", busy, credit, change_valid);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_exact_price();
    test_change();
    test_change_multi();
    test_denial();
    test_overflow();
    test_collision();
    test_cancel();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
